// File: rtl/hsv_core_fetch_buffer_if.sv
// ============================================================================
// hsv_core_fetch_buffer_if : fetch-beat type and fetch->decode buffer bus
// Revision : 1.0
// ============================================================================
`default_nettype none

package hsv_core_fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        fault;
        logic [2:0]  pc_increment;
    } fetch_data_t;
endpackage

interface hsv_core_fetch_buffer_if #(
    parameter int DEPTH = 8
);
    hsv_core_fetch_pkg::fetch_data_t fetch_data;
    logic                            valid_i;
    logic                            ready_o;
    hsv_core_fetch_pkg::fetch_data_t decode_data;
    logic                            valid_o;
    logic                            ready_i;
    logic                            flush_req;
    logic                            flush_ack;
    logic [$clog2(DEPTH):0]          level;

    modport slave (
        input  fetch_data, valid_i, ready_i, flush_req,
        output ready_o, decode_data, valid_o, flush_ack, level
    );

    modport master (
        output fetch_data, valid_i, ready_i, flush_req,
        input  ready_o, decode_data, valid_o, flush_ack, level
    );
endinterface

`default_nettype wire

// File: rtl/hsv_core_fetch_buffer.sv
// ============================================================================
// hsv_core_fetch_buffer : in-order instruction queue between fetch and decode
// Optional macro HSV_FETCH_BUFFER_BYPASS_EN: zero-latency path when empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hsv_core_fetch_buffer #(
    parameter int DEPTH = 8
) (
    input  wire logic              clk_core,
    input  wire logic              rst_core,
    hsv_core_fetch_buffer_if.slave bus
);
    import hsv_core_fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic        halted_q, halted_d;
    fetch_data_t mem_q [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_take;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign bus.flush_ack = bus.flush_req & empty;
    assign bus.level     = wr_ptr_q - rd_ptr_q;

    always_comb begin
        // During flush everything is accepted and dropped so imem bursts drain
        bus.ready_o     = bus.flush_req | (~full & ~halted_q);
        bus.valid_o     = ~empty & ~bus.flush_req;
        bus.decode_data = mem_q[rd_ptr_q[AW-1:0]];
        bypass_take     = 1'b0;
`ifdef HSV_FETCH_BUFFER_BYPASS_EN
        if (empty && !bus.flush_req && !halted_q) begin
            bus.valid_o     = bus.valid_i;
            bus.decode_data = bus.fetch_data;
            bypass_take     = bus.valid_i & bus.ready_i;
        end
`endif
        push = bus.valid_i & bus.ready_o & ~bus.flush_req & ~bypass_take;
        pop  = bus.valid_o & bus.ready_i & ~bypass_take;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + ptr_t'(push);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop);
        halted_d = halted_q | ((push | bypass_take) & bus.fetch_data.fault);
        if (bus.flush_req) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            halted_d = 1'b0;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            halted_q <= halted_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid
    always_ff @(posedge clk_core) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.fetch_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hsv_core_fetch_buffer.sv
// ============================================================================
// tb_hsv_core_fetch_buffer : directed + scoreboard bench for the fetch buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hsv_core_fetch_buffer;
    import hsv_core_fetch_pkg::*;

    localparam int DEPTH = 8;

    logic clk_core = 1'b0;
    logic rst_core = 1'b1;

    always #5 clk_core = ~clk_core;

    hsv_core_fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    hsv_core_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_core (clk_core),
        .rst_core (rst_core),
        .bus      (bus.slave)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_level = 0;
    bit          m_halt  = 1'b0;
    bit          m_acc   = 1'b0;
    fetch_data_t sb[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic fetch_data_t mk(input logic [31:0] pc, input logic flt);
        fetch_data_t b;
        b.pc           = pc;
        b.insn         = pc ^ 32'hA5A5_0000;
        b.fault        = flt;
        b.pc_increment = 3'd4;
        return b;
    endfunction

    // One clock cycle: drive, check against the reference model, advance model
    task automatic step(input logic v, input logic [31:0] pc, input logic flt,
                        input logic rdy, input logic fl);
        fetch_data_t beat;
        fetch_data_t head;
        logic        e_valid;
        logic        e_ready;
        logic        byp;
        logic        take;
        beat           = mk(pc, flt);
        bus.valid_i    = v;
        bus.fetch_data = beat;
        bus.ready_i    = rdy;
        bus.flush_req  = fl;
        @(negedge clk_core);
        e_ready = fl || ((m_level < DEPTH) && !m_halt);
        e_valid = (m_level != 0) && !fl;
        byp     = 1'b0;
`ifdef HSV_FETCH_BUFFER_BYPASS_EN
        if (m_level == 0 && !fl && !m_halt) begin
            byp     = 1'b1;
            e_valid = v;
        end
`endif
        chk("ready_o",   128'(bus.ready_o),   128'(e_ready));
        chk("valid_o",   128'(bus.valid_o),   128'(e_valid));
        chk("flush_ack", 128'(bus.flush_ack), 128'(fl && (m_level == 0)));
        chk("level",     128'(bus.level),     128'(m_level));
        take  = 1'b0;
        m_acc = 1'b0;
        if (byp && v && rdy) begin
            chk("bypass_data", 128'(bus.decode_data), 128'(beat));
            take  = 1'b1;
            m_acc = 1'b1;
            if (flt) m_halt = 1'b1;
        end else if (e_valid && rdy) begin
            head = sb.pop_front();
            chk("decode_data", 128'(bus.decode_data), 128'(head));
            m_level--;
        end
        if (fl) begin
            sb.delete();
            m_level = 0;
            m_halt  = 1'b0;
        end else if (v && e_ready && !take) begin
            sb.push_back(beat);
            m_level++;
            m_acc = 1'b1;
            if (flt) m_halt = 1'b1;
        end
        @(posedge clk_core);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 4 * DEPTH) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_done", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        logic [31:0] npc;
        int          acc;
        int          guard;
        bus.valid_i    = 1'b0;
        bus.fetch_data = mk(32'h0, 1'b0);
        bus.ready_i    = 1'b0;
        bus.flush_req  = 1'b0;

        // Reset values while rst_core is high
        @(negedge clk_core);
        chk("rst_level",     128'(bus.level),     128'(0));
        chk("rst_valid_o",   128'(bus.valid_o),   128'(0));
        chk("rst_ready_o",   128'(bus.ready_o),   128'(1));
        chk("rst_flush_ack", 128'(bus.flush_ack), 128'(0));
        bus.flush_req = 1'b1;
        #1;
        chk("rst_flush_ack_hi", 128'(bus.flush_ack), 128'(1));
        bus.flush_req = 1'b0;
        @(posedge clk_core);
        #1;
        rst_core = 1'b0;

        // Streaming with decode always ready
        for (int i = 0; i < 20; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b1, 1'b0);
        drain();

        // Fill with decode stalled, then drain
        for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        chk("fill_level", 128'(m_level), 128'(DEPTH));
        step(1'b1, 32'h300, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drain();

        // Flush with 5 entries held and beats still arriving
        for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        drain();

        // Fault halts acceptance until a flush
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'h18, 1'b0, 1'b1, 1'b0);
        chk("fault_halted", 128'(m_halt), 128'(1));
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Wrap-around with random decode stalls
        npc   = 32'h1000;
        acc   = 0;
        guard = 0;
        while (acc < 3 * DEPTH && guard < 400) begin
            step(1'b1, npc, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (m_acc) begin
                acc++;
                npc = npc + 32'd4;
            end
            guard++;
        end
        chk("wrap_accepted", 128'(acc), 128'(3 * DEPTH));
        drain();

        // Single beat into an empty buffer with decode ready
        step(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
        drain();

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        bus.valid_i = 1'b0;
        #2;
        rst_core = 1'b1;
        #1;
        chk("arst_level",   128'(bus.level),   128'(0));
        chk("arst_valid_o", 128'(bus.valid_o), 128'(0));
        chk("arst_ready_o", 128'(bus.ready_o), 128'(1));
        sb.delete();
        m_level = 0;
        m_halt  = 1'b0;
        @(posedge clk_core);
        #1;
        rst_core = 1'b0;
        step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
